cgra_tile_config_sink: RTL

- Per-tile receiver for the CGRA configuration bus: the consumer end of the address/data stream the configuration driver presents once per cycle on config_addr_in/config_data_in.
- Decodes writes addressed to this tile into a local register bank, answers readback requests, counts accepted writes and flags end of configuration.
- Instantiated once per tile under top; its register outputs feed the tile's PE/switch-box mux selects.

---
 rtl/cgra_tile_config_sink.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cgra_tile_config_sink.sv
// cgra_tile_config_sink: per-tile consumer of the CGRA configuration bus.
// Decodes tile-addressed writes into a local register bank, answers readback
// requests, counts accepted writes and flags end of configuration once the
// bus has been quiet (null cycles) for IDLE_LIMIT consecutive cycles.
// Optional feature macro: CONFIG_SHADOW_EN -- writes land in a shadow bank
// that is copied whole into the active bank when configuration completes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | reset state, waiting for the first write to this tile
// LOADING | writes in progress, counting consecutive null cycles
// DONE    | bus quiet for IDLE_LIMIT cycles, configuration complete

module cgra_tile_config_sink #(
    parameter logic [15:0] TILE_ID    = 16'h0015,
    parameter int          NUM_REGS   = 8,
    parameter int          IDLE_LIMIT = 4
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [31:0]              config_addr_in,
    input  logic [31:0]              config_data_in,
    output logic [32*NUM_REGS-1:0]   cfg_regs_out,
    output logic [31:0]              read_data_out,
    output logic                     read_valid_out,
    output logic [15:0]              write_count_out,
    output logic                     config_done_out,
    output logic                     err_out
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = $clog2(IDLE_LIMIT + 1);
    localparam logic [8:0]       NUM_REGS_W = 9'(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(IDLE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(IDLE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] idle_cnt;
    logic [31:0]      active_bank [NUM_REGS];

    logic [7:0]       opcode;
    logic [7:0]       index;
    logic [IDX_W-1:0] idx_sel;
    logic             hit, is_null, idx_ok, op_wr, op_rd;
    logic             wr_hit, wr_ok, rd_ok, err_hit;

    assign opcode  = config_addr_in[23:16];
    assign index   = config_addr_in[31:24];
    assign idx_sel = index[IDX_W-1:0];
    assign hit     = (config_addr_in[15:0] == TILE_ID);
    assign is_null = (config_addr_in == 32'h0);
    assign idx_ok  = ({1'b0, index} < NUM_REGS_W);
    assign op_wr   = (opcode == 8'h00);
    assign op_rd   = (opcode == 8'h80);
    // A write-opcode hit advances the FSM even if its index is out of range.
    assign wr_hit  = hit && op_wr;
    assign wr_ok   = wr_hit && idx_ok;
    assign rd_ok   = hit && op_rd && idx_ok;
    assign err_hit = hit && (!idx_ok || !(op_wr || op_rd));

    // Flatten the bank onto the output bus, register i at [32*i +: 32].
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_regs_out[32*g +: 32] = active_bank[g];
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // FSM next-state: enter DONE on the IDLE_LIMIT-th consecutive null.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (wr_hit) state_d = LOADING;
            LOADING: if (is_null && idle_cnt == CNT_LAST) state_d = DONE;
            DONE:    if (wr_hit) state_d = LOADING;
            default: state_d = IDLE;
        endcase
    end

    // Null-run counter, only live in LOADING; saturates at IDLE_LIMIT.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            idle_cnt <= '0;
        end else if (state_q == LOADING && is_null) begin
            if (idle_cnt != CNT_MAX) idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end

    assign config_done_out = (state_q == DONE);

`ifdef CONFIG_SHADOW_EN
    logic [31:0] shadow_bank [NUM_REGS];
    logic        enter_done;

    assign enter_done = (state_d == DONE) && (state_q != DONE);

    // Writes fill the shadow bank; the whole bank commits when DONE is reached.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_bank[i] <= '0;
                active_bank[i] <= '0;
            end
        end else begin
            if (wr_ok) shadow_bank[idx_sel] <= config_data_in;
            if (enter_done) begin
                for (int i = 0; i < NUM_REGS; i++) active_bank[i] <= shadow_bank[i];
            end
        end
    end
`else
    // Writes land directly in the active bank.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) active_bank[i] <= '0;
        end else if (wr_ok) begin
            active_bank[idx_sel] <= config_data_in;
        end
    end
`endif

    // Readback: one-cycle valid pulse, data holds between reads.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            read_data_out  <= '0;
            read_valid_out <= 1'b0;
        end else begin
            read_valid_out <= rd_ok;
            if (rd_ok) read_data_out <= active_bank[idx_sel];
        end
    end

    // Accepted-write counter, saturating.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in)                            write_count_out <= '0;
        else if (wr_ok && write_count_out != 16'hFFFF) write_count_out <= write_count_out + 16'd1;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in)    err_out <= 1'b0;
        else if (err_hit) err_out <= 1'b1;
    end

endmodule
